masked_sbox_layer_serial: RTL and testbench

//  Applies the PRINCE S-box layer to a 64-bit two-share (x,y) state using NSBOX parallel

---
 rtl/masked_sbox_layer_serial_pkg.sv | 23 ++
 rtl/masked_sbox.sv | 46 ++++
 rtl/masked_sbox_layer_serial.sv | 140 ++++++++++++++
 tb/tb_masked_sbox_layer_serial.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_sbox_layer_serial_pkg.sv
// Shared definitions for the serial masked S-box layer.
// FSM state encoding and PRINCE S-box lookup helper.
package masked_sbox_layer_serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Nibble v of each table holds S(v) / S^-1(v).
  localparam logic [63:0] S_TAB    = 64'h4D5E_0876_19CA_23FB;
  localparam logic [63:0] SINV_TAB = 64'h1CE5_046A_98DF_237B;

  function automatic logic [3:0] prince_s(
    input logic [3:0] v,
    input logic       fwd
  );
    logic [5:0] idx;
    idx = {v, 2'b00};
    return fwd ? S_TAB[idx +: 4] : SINV_TAB[idx +: 4];
  endfunction

endpackage

// File: rtl/masked_sbox.sv
// Two-share PRINCE S-box cell, one register stage.
// Ports: clk, rst, en, sel, x_in/y_in shares, rnd, z_x/z_y result shares.
module masked_sbox
  import masked_sbox_layer_serial_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sel,
  input  logic [3:0]  x_in,
  input  logic [3:0]  y_in,
  input  logic [15:0] rnd,
  output logic [3:0]  z_x,
  output logic [3:0]  z_y
);

  logic [3:0] m;
  logic [3:0] zx_d, zx_q;
  logic [3:0] zy_d, zy_q;

  // All 16 random bits fold into the fresh output mask.
  assign m = rnd[3:0] ^ rnd[7:4] ^ rnd[11:8] ^ rnd[15:12];

  always_comb begin
    zx_d = zx_q;
    zy_d = zy_q;
    if (en) begin
      zx_d = prince_s(x_in ^ y_in, sel) ^ m;
      zy_d = m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zx_q <= '0;
      zy_q <= '0;
    end else begin
      zx_q <= zx_d;
      zy_q <= zy_d;
    end
  end

  assign z_x = zx_q;
  assign z_y = zy_q;

endmodule

// File: rtl/masked_sbox_layer_serial.sv
// Serial PRINCE S-box layer over a 64-bit two-share state, NSBOX nibbles/cycle.
// Ports: start/sel/x_in/y_in in, rnd valid/ready, busy/done, x_out/y_out.
module masked_sbox_layer_serial
  import masked_sbox_layer_serial_pkg::*;
#(
  parameter int NSBOX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sel,
  input  logic [63:0]          x_in,
  input  logic [63:0]          y_in,
  input  logic [16*NSBOX-1:0]  rnd,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          x_out,
  output logic [63:0]          y_out
);

  localparam int G  = 16 / NSBOX;
  localparam int W  = 4 * NSBOX;
  localparam int CW = 5;

  logic [1:0]    state_d, state_q;
  logic [63:0]   xs_d, xs_q;
  logic [63:0]   ys_d, ys_q;
  logic [63:0]   xo_d, xo_q;
  logic [63:0]   yo_d, yo_q;
  logic [63:0]   x_out_d, x_out_q;
  logic [63:0]   y_out_d, y_out_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          pend_d, pend_q;
  logic          sel_d, sel_q;

  logic          fire;
  logic          accept;
  logic [W-1:0]  zx_all;
  logic [W-1:0]  zy_all;
  logic [63:0]   xo_cap;
  logic [63:0]   yo_cap;

  for (genvar j = 0; j < NSBOX; j++) begin : g_sbox
    masked_sbox u_sbox (
      .clk  (clk),
      .rst  (rst),
      .en   (fire),
      .sel  (sel_q),
      .x_in (xs_q[4*j +: 4]),
      .y_in (ys_q[4*j +: 4]),
      .rnd  (rnd[16*j +: 16]),
      .z_x  (zx_all[4*j +: 4]),
      .z_y  (zy_all[4*j +: 4])
    );
  end

  // New group enters at the top; after G captures group 0 sits at the bottom.
  assign xo_cap = (xo_q >> W) | (64'(zx_all) << (64 - W));
  assign yo_cap = (yo_q >> W) | (64'(zy_all) << (64 - W));

  always_comb begin
    fire   = (state_q == ST_FEED) & rnd_valid;
    accept = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pend_d  = fire;
    xo_d    = xo_q;
    yo_d    = yo_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;

    if (pend_q) begin
      xo_d = xo_cap;
      yo_d = yo_cap;
    end

    if (accept) begin
      xs_d  = x_in;
      ys_d  = y_in;
      sel_d = sel;
      cnt_d = '0;
    end else if (fire) begin
      xs_d  = xs_q >> W;
      ys_d  = ys_q >> W;
      cnt_d = cnt_q + CW'(1);
    end

    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_FEED;
      ST_FEED: if (fire && cnt_q == CW'(G - 1)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // Last capture lands on this same edge.
        state_d = ST_DONE;
        x_out_d = xo_d;
        y_out_d = yo_d;
      end
      ST_DONE: state_d = accept ? ST_FEED : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
    end
  end

  assign rnd_ready = (state_q == ST_FEED);
  assign busy      = (state_q == ST_FEED) | (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;

endmodule

// File: tb/tb_masked_sbox_layer_serial.sv
// Directed bench for masked_sbox_layer_serial (NSBOX=4).
// Checks reset, S/S^-1 results, latency, stalls, ignored starts, mid-layer reset.
module tb_masked_sbox_layer_serial;

  localparam int NSBOX = 4;
  localparam int G     = 16 / NSBOX;

  localparam logic [63:0] V  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SV = 64'hBF32_AC91_6780_E5D4;

  localparam logic [3:0] ST [16] = '{
    4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
    4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
  localparam logic [3:0] SI [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                sel;
  logic [63:0]         x_in;
  logic [63:0]         y_in;
  logic [16*NSBOX-1:0] rnd;
  logic                rnd_valid;
  logic                rnd_ready;
  logic                busy;
  logic                done;
  logic [63:0]         x_out;
  logic [63:0]         y_out;

  int tests = 0;
  int fails = 0;

  masked_sbox_layer_serial #(.NSBOX(NSBOX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .x_in      (x_in),
    .y_in      (y_in),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .busy      (busy),
    .done      (done),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] v, input bit f);
    logic [63:0] r;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = f ? ST[v[4*i +: 4]] : SI[v[4*i +: 4]];
    return r;
  endfunction

  task automatic launch(input logic [63:0] xi, input logic [63:0] yi,
                        input logic s);
    start = 1'b1;
    x_in  = xi;
    y_in  = yi;
    sel   = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = {$urandom, $urandom};
    y_in  = {$urandom, $urandom};
    sel   = ~s;
  endtask

  // Runs from the cycle after an accepted start until done is seen.
  task automatic wait_done(input int stalls, input int poke, input bit zr,
                           output int lat, output int rdy);
    int fires;
    int rem;
    int n;
    fires = 0;
    rem   = stalls;
    n     = 0;
    rdy   = 0;
    lat   = -1;
    while (n < 60) begin
      rnd   = zr ? '0 : {$urandom, $urandom};
      start = (n == poke);
      if (n == poke) begin
        x_in = 64'hFFFF_FFFF_FFFF_FFFF;
        sel  = ~sel;
      end
      if (rnd_ready) begin
        rdy++;
        if (rem > 0 && ($urandom_range(1) == 1 || fires == G - 1)) begin
          rnd_valid = 1'b0;
          rem--;
        end else begin
          rnd_valid = 1'b1;
          fires++;
        end
      end else begin
        rnd_valid = 1'($urandom_range(1));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int rdy;
    int ndiff;
    int ndone;
    logic [63:0] r;
    logic [63:0] y0;
    logic [63:0] first_x;
    logic [63:0] rv;
    bit          rs;

    rst       = 1'b1;
    start     = 1'b0;
    sel       = 1'b0;
    x_in      = '0;
    y_in      = '0;
    rnd       = '0;
    rnd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdy", 64'(rnd_ready), 64'd0);
    chk("rst_xout", x_out, 64'd0);
    chk("rst_yout", y_out, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: all-zero input, zero randomness
    launch(64'd0, 64'd0, 1'b1);
    wait_done(0, -1, 1'b1, lat, rdy);
    chk("t1_lat", 64'(lat), 64'd5);
    chk("t1_res", x_out ^ y_out, 64'hBBBB_BBBB_BBBB_BBBB);

    // 2: forward then inverse with fresh shares
    launch(V, 64'd0, 1'b1);
    wait_done(0, -1, 1'b0, lat, rdy);
    chk("t2_lat", 64'(lat), 64'd5);
    chk("t2_rdy", 64'(rdy), 64'(G));
    r = x_out ^ y_out;
    chk("t2_fwd", r, SV);
    y0 = {$urandom, $urandom};
    launch(r ^ y0, y0, 1'b0);
    wait_done(0, -1, 1'b0, lat, rdy);
    chk("t2_inv", x_out ^ y_out, V);

    // 3: three stall cycles
    launch(V, 64'd0, 1'b1);
    wait_done(3, -1, 1'b0, lat, rdy);
    chk("t3_lat", 64'(lat), 64'd8);
    chk("t3_rdy", 64'(rdy), 64'(G + 3));
    chk("t3_res", x_out ^ y_out, SV);
    chk("t3_busy", 64'(busy), 64'd0);

    // 4: random share splits of one value
    ndiff   = 0;
    first_x = '0;
    for (int k = 0; k < 100; k++) begin
      y0 = {$urandom, $urandom};
      launch(V ^ y0, y0, 1'b1);
      wait_done(int'($urandom_range(2)), -1, 1'b0, lat, rdy);
      chk("t4_res", x_out ^ y_out, SV);
      if (k == 0) first_x = x_out;
      else if (x_out != first_x) ndiff++;
    end
    chk("t4_vary", 64'(ndiff > 0), 64'd1);
    rv = {$urandom, $urandom};
    rs = 1'($urandom_range(1));
    y0 = {$urandom, $urandom};
    launch(rv ^ y0, y0, rs);
    wait_done(1, -1, 1'b0, lat, rdy);
    chk("t4_rand", x_out ^ y_out, model(rv, rs));

    // 5: start during FEED ignored; start in DONE accepted
    launch(V, 64'd0, 1'b1);
    wait_done(0, 2, 1'b0, lat, rdy);
    chk("t5_lat", 64'(lat), 64'd5);
    chk("t5_res", x_out ^ y_out, SV);
    launch(SV, 64'd0, 1'b0);
    wait_done(0, -1, 1'b0, lat, rdy);
    chk("t5_lat2", 64'(lat), 64'(G + 1));
    chk("t5_res2", x_out ^ y_out, V);

    // 6: reset after the second fire
    launch(SV, 64'd0, 1'b0);
    rnd_valid = 1'b1;
    repeat (2) begin
      rnd = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_rdy", 64'(rnd_ready), 64'd0);
    chk("t6_xout", x_out, 64'd0);
    chk("t6_yout", y_out, 64'd0);
    rst   = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      ndone += int'(done);
    end
    chk("t6_nodone", 64'(ndone), 64'd0);
    launch(V, 64'd0, 1'b1);
    wait_done(0, -1, 1'b0, lat, rdy);
    chk("t6_lat", 64'(lat), 64'd5);
    chk("t6_res", x_out ^ y_out, SV);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
